// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmitter: keyboard command bytes,
// FSM state encoding and the frame parity helper.
package ps2_host_tx_pkg;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INHIBIT   = 3'd1;
    localparam logic [2:0] ST_RTS       = 3'd2;
    localparam logic [2:0] ST_SHIFT     = 3'd3;
    localparam logic [2:0] ST_ACK       = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    // Stability window applied to the PS/2 clock pin before edge detection.
    localparam int unsigned PS2_DEBOUNCE_CYCLES = 8;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/debounce.sv
// Synchronises an asynchronous pin and only follows it once it has been stable
// for STABLE_CYCLES cycles; output lags the pin by 2 + STABLE_CYCLES cycles.
module debounce #(
    parameter int unsigned STABLE_CYCLES = 8,
    parameter logic        RESET_VAL     = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    output logic dout_o
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          dout_q, dout_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        dout_d = dout_q;
        cnt_d  = cnt_q;
        if (sync2_q == dout_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            dout_d = sync2_q;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
            dout_q  <= RESET_VAL;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout_o = dout_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 10 shifted bits, device ACK.
// One byte in flight; tx_ready only in IDLE, tx_valid is ignored while busy.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 2500,
    parameter int unsigned TIMEOUT_CYCLES = 375000
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic       key_clk,
    input  logic       key_din,
    output logic       key_clk_oe,
    output logic       key_din_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_ack_err,
    output logic       tx_timeout
);

    localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_SAT   = TW'(TIMEOUT_CYCLES);

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] inh_cnt_q, inh_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [9:0]    frame_q, frame_d;
    logic [3:0]    bit_idx_q, bit_idx_d;
    logic          din_drv_q, din_drv_d;
    logic          din_s1_q, din_s2_q;
    logic          clk_db, clk_db_prev_q;
    logic          clk_fall, to_running, timed_out;

    debounce #(
        .STABLE_CYCLES (PS2_DEBOUNCE_CYCLES),
        .RESET_VAL     (1'b1)
    ) u_clk_db (
        .clk_i  (clk25),
        .rst_i  (rst),
        .din_i  (key_clk),
        .dout_o (clk_db)
    );

    always_ff @(posedge clk25) begin
        if (rst) begin
            din_s1_q      <= 1'b1;
            din_s2_q      <= 1'b1;
            clk_db_prev_q <= 1'b1;
        end else begin
            din_s1_q      <= key_din;
            din_s2_q      <= din_s1_q;
            clk_db_prev_q <= clk_db;
        end
    end

    assign clk_fall   = clk_db_prev_q & ~clk_db;
    assign to_running = (state_q == ST_SHIFT) || (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE);
    assign timed_out  = to_running && (to_cnt_q == TO_LAST);

    always_ff @(posedge clk25) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            inh_cnt_q <= '0;
            to_cnt_q  <= '0;
            frame_q   <= '0;
            bit_idx_q <= '0;
            din_drv_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            frame_q   <= frame_d;
            bit_idx_q <= bit_idx_d;
            din_drv_q <= din_drv_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        frame_d   = frame_q;
        bit_idx_d = bit_idx_q;
        din_drv_d = din_drv_q;

        if (to_running && (to_cnt_q != TO_SAT)) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    // Frame bits 0..9 in wire order: data LSB first, parity, stop.
                    frame_d   = {1'b1, odd_parity(tx_data), tx_data};
                    inh_cnt_d = '0;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    state_d = ST_RTS;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end
            ST_RTS: begin
                to_cnt_d  = '0;
                bit_idx_d = '0;
                din_drv_d = 1'b1;
                state_d   = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (timed_out) begin
                    state_d = ST_IDLE;
                end else if (clk_fall) begin
                    din_drv_d = ~frame_q[bit_idx_q];
                    if (bit_idx_q == 4'd9) begin
                        state_d = ST_ACK;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            ST_ACK: begin
                if (timed_out) begin
                    state_d = ST_IDLE;
                end else if (clk_fall) begin
                    state_d = din_s2_q ? ST_IDLE : ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (timed_out || (clk_db && din_s2_q)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        tx_ready   = (state_q == ST_IDLE);
        busy       = (state_q != ST_IDLE);
        key_clk_oe = (state_q == ST_INHIBIT) || (state_q == ST_RTS);
        key_din_oe = (state_q == ST_RTS) || ((state_q == ST_SHIFT) && din_drv_q);
        tx_timeout = timed_out;
        tx_ack_err = (state_q == ST_ACK) && !timed_out && clk_fall && din_s2_q;
        tx_done    = (state_q == ST_WAIT_IDLE) && !timed_out && clk_db && din_s2_q;
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Drives ps2_host_tx against a PS/2 device model on an open-drain bus and checks
// inhibit timing, frame bits, parity, ACK handling, timeout and mid-frame reset.
module tb_ps2_host_tx;
    import ps2_host_tx_pkg::*;

    localparam int INH  = 50;
    localparam int TO   = 3000;
    localparam int HALF = 40;

    logic       clk25 = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       dev_clk_low = 1'b0;
    logic       dev_din_low = 1'b0;
    logic       key_clk, key_din;
    logic       key_clk_oe, key_din_oe, tx_ready, busy, tx_done, tx_ack_err, tx_timeout;

    int  vectors = 0;
    int  miscompares = 0;
    int  done_cnt = 0, err_cnt = 0, to_cnt = 0, multi_cnt = 0;
    int  cyc = 0, to_cyc = 0;
    bit  hold_mode = 1'b0;

    always #20 clk25 = ~clk25;

    // Open-drain wired-AND of host and device pull-downs.
    assign key_clk = ~(key_clk_oe | dev_clk_low);
    assign key_din = ~(key_din_oe | dev_din_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk25      (clk25),
        .rst        (rst),
        .key_clk    (key_clk),
        .key_din    (key_din),
        .key_clk_oe (key_clk_oe),
        .key_din_oe (key_din_oe),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .tx_done    (tx_done),
        .tx_ack_err (tx_ack_err),
        .tx_timeout (tx_timeout)
    );

    always @(negedge clk25) begin
        cyc++;
        if (tx_done) done_cnt++;
        if (tx_ack_err) err_cnt++;
        if (tx_timeout) begin
            to_cnt++;
            to_cyc = cyc;
        end
        if ((int'(tx_done) + int'(tx_ack_err) + int'(tx_timeout)) > 1) multi_cnt++;
    end

    task automatic tick();
        @(posedge clk25);
        #1;
        if (hold_mode) tx_data = 8'($urandom);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Wire-order frame as the device sees it: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] ref_frame(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = (((d >> i) & 8'd1) != 0);
        f[9]  = ($countones(d) % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic send_frame(input logic [7:0] d, input bit ack, input int n_clk,
                              input bit hold, input string tag, input int rst_edge);
        int          d0, e0, t0, inh, rel;
        logic [10:0] exp_f, seen;
        d0 = done_cnt; e0 = err_cnt; t0 = to_cnt;
        exp_f = ref_frame(d);
        seen = '0;
        tx_data = d;
        tx_valid = 1'b1;
        tick();
        hold_mode = hold;
        if (!hold) tx_valid = 1'b0;
        check({tag, "_busy"}, 32'(busy), 1);
        check({tag, "_ready_low"}, 32'(tx_ready), 0);

        inh = 0;
        for (int i = 0; i < INH + 20 && key_din_oe !== 1'b1; i++) begin
            if (key_clk_oe === 1'b1) inh++;
            tick();
        end
        check({tag, "_inhibit_len"}, 32'(inh), INH);
        check({tag, "_rts_din_oe"}, 32'(key_din_oe), 1);
        check({tag, "_rts_clk_oe"}, 32'(key_clk_oe), 1);
        tick();
        check({tag, "_release_clk_oe"}, 32'(key_clk_oe), 0);
        check({tag, "_start_din_oe"}, 32'(key_din_oe), 1);
        rel = cyc;

        for (int e = 0; e < n_clk; e++) begin
            repeat (HALF) tick();
            if (e <= 10) seen[e] = key_din;
            if (e == 10 && ack) dev_din_low = 1'b1;
            dev_clk_low = 1'b1;
            if (e == rst_edge) begin
                repeat (HALF / 2) tick();
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check({tag, "_rst_clk_oe"}, 32'(key_clk_oe), 0);
                check({tag, "_rst_din_oe"}, 32'(key_din_oe), 0);
                check({tag, "_rst_busy"}, 32'(busy), 0);
                dev_clk_low = 1'b0;
                repeat (HALF) tick();
                check({tag, "_rst_no_pulse"},
                      32'((done_cnt - d0) + (err_cnt - e0) + (to_cnt - t0)), 0);
                check({tag, "_rst_idle"}, 32'(tx_ready), 1);
                for (int b = 0; b <= e; b++)
                    check($sformatf("%s_bit%0d", tag, b), 32'(seen[b]), 32'(exp_f[b]));
                return;
            end
            repeat (HALF) tick();
            dev_clk_low = 1'b0;
        end

        if (hold) tx_valid = 1'b0;
        repeat (HALF / 2) tick();
        dev_din_low = 1'b0;
        for (int i = 0; i < TO + 100 &&
             (done_cnt + err_cnt + to_cnt) == (d0 + e0 + t0); i++) tick();
        hold_mode = 1'b0;
        repeat (4) tick();

        check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'(n_clk == 11 && ack));
        check({tag, "_err_pulses"}, 32'(err_cnt - e0), 32'(n_clk == 11 && !ack));
        check({tag, "_to_pulses"}, 32'(to_cnt - t0), 32'(n_clk == 0));
        check({tag, "_end_clk_oe"}, 32'(key_clk_oe), 0);
        check({tag, "_end_din_oe"}, 32'(key_din_oe), 0);
        check({tag, "_end_busy"}, 32'(busy), 0);
        check({tag, "_end_ready"}, 32'(tx_ready), 1);
        if (n_clk == 0)
            check({tag, "_to_latency"}, 32'(to_cyc - rel), TO);
        if (n_clk == 11)
            for (int b = 0; b < 11; b++)
                check($sformatf("%s_bit%0d", tag, b), 32'(seen[b]), 32'(exp_f[b]));
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        check("reset_clk_oe", 32'(key_clk_oe), 0);
        check("reset_din_oe", 32'(key_din_oe), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_pulses", 32'({tx_done, tx_ack_err, tx_timeout}), 0);
        rst = 1'b0;
        tick();
        check("reset_ready", 32'(tx_ready), 1);

        send_frame(PS2_CMD_ENABLE, 1'b1, 11, 1'b0, "f4", -1);
        send_frame(PS2_CMD_SET_LEDS, 1'b1, 11, 1'b0, "ed", -1);
        send_frame(PS2_CMD_ENABLE, 1'b0, 11, 1'b0, "ackerr", -1);
        send_frame(PS2_CMD_RESET, 1'b1, 0, 1'b0, "timeout", -1);
        send_frame(8'($urandom), 1'b1, 11, 1'b1, "hold", -1);
        send_frame(8'($urandom), 1'b1, 11, 1'b0, "midrst", 4);
        send_frame(PS2_CMD_RESET, 1'b1, 11, 1'b0, "ff", -1);
        for (int k = 0; k < 3; k++)
            send_frame(8'($urandom), 1'b1, 11, 1'b0, $sformatf("rnd%0d", k), -1);

        check("pulse_exclusive", 32'(multi_cnt), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
